// File: rtl/hit_resolver.sv
// Per-frame hit arbitration for a two-fighter game: geometry test, block/hit decision,
// health and hitstun bookkeeping, and round-end detection with winner reporting.
module hit_resolver #(
    parameter int unsigned SPRITE_W       = 64,
    parameter int unsigned ATK_REACH      = 32,
    parameter int unsigned HEALTH_MAX     = 100,
    parameter int unsigned DAMAGE         = 10,
    parameter int unsigned HITSTUN_FRAMES = 12,
    parameter logic [2:0]  ST_ACTIVE      = 3'd5,
    parameter logic [2:0]  ST_BWD         = 3'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_round,
    input  logic [9:0] p1_x,
    input  logic [2:0] p1_state,
    input  logic [9:0] p2_x,
    input  logic [2:0] p2_state,
    output logic       p1_hit,
    output logic       p2_hit,
    output logic       p1_blocked,
    output logic       p2_blocked,
    output logic [7:0] p1_health,
    output logic [7:0] p2_health,
    output logic       p1_stun,
    output logic       p2_stun,
    output logic       round_over,
    output logic [1:0] winner
);

    typedef enum logic {FIGHT = 1'b0, OVER = 1'b1} round_state_t;

    localparam logic [10:0] FAR_EDGE   = 11'(SPRITE_W - 1 + ATK_REACH);
    localparam logic [7:0]  HEALTH_INI = 8'(HEALTH_MAX);
    localparam logic [7:0]  DMG        = 8'(DAMAGE);
    localparam logic [5:0]  STUN_INI   = 6'(HITSTUN_FRAMES);

    round_state_t state_q, state_d;
    logic         in_fight, in_over, restart;

    logic [5:0] p1_stun_cnt, p2_stun_cnt;
    logic       p1_conn, p2_conn;
    logic       overlap;
    logic       p1_cand, p2_cand;
    logic       p1_hit_ev, p2_hit_ev, p1_block_ev, p2_block_ev;

    // Both attacks reduce to the same inequality because the fighters face each other.
    assign overlap = ({1'b0, p2_x} >= ({1'b0, p1_x} + 11'd1)) &&
                     ({1'b0, p2_x} <= ({1'b0, p1_x} + FAR_EDGE));

    assign p1_cand = in_fight && (p1_state == ST_ACTIVE) && overlap &&
                     !p1_conn && (p2_stun_cnt == 6'd0);
    assign p2_cand = in_fight && (p2_state == ST_ACTIVE) && overlap &&
                     !p2_conn && (p1_stun_cnt == 6'd0);

    assign p2_block_ev = p1_cand && (p2_state == ST_BWD);
    assign p2_hit_ev   = p1_cand && (p2_state != ST_BWD);
    assign p1_block_ev = p2_cand && (p1_state == ST_BWD);
    assign p1_hit_ev   = p2_cand && (p1_state != ST_BWD);

    // Round FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FIGHT;
        else       state_q <= state_d;
    end

    // Round FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            FIGHT: if ((p1_health == 8'd0) || (p2_health == 8'd0)) state_d = OVER;
            OVER:  if (new_round) state_d = FIGHT;
            default: state_d = FIGHT;
        endcase
    end

    // Round FSM: outputs
    always_comb begin
        in_fight   = (state_q == FIGHT);
        in_over    = (state_q == OVER);
        restart    = in_over && new_round;
        round_over = in_over;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_hit      <= 1'b0;
            p2_hit      <= 1'b0;
            p1_blocked  <= 1'b0;
            p2_blocked  <= 1'b0;
            p1_health   <= HEALTH_INI;
            p2_health   <= HEALTH_INI;
            p1_stun_cnt <= 6'd0;
            p2_stun_cnt <= 6'd0;
            p1_conn     <= 1'b0;
            p2_conn     <= 1'b0;
            winner      <= 2'b00;
        end else begin
            p1_hit     <= p1_hit_ev;
            p2_hit     <= p2_hit_ev;
            p1_blocked <= p1_block_ev;
            p2_blocked <= p2_block_ev;
            if (restart) begin
                p1_health   <= HEALTH_INI;
                p2_health   <= HEALTH_INI;
                p1_stun_cnt <= 6'd0;
                p2_stun_cnt <= 6'd0;
                p1_conn     <= 1'b0;
                p2_conn     <= 1'b0;
                winner      <= 2'b00;
            end else begin
                if (p1_hit_ev)
                    p1_health <= (p1_health < DMG) ? 8'd0 : p1_health - DMG;
                if (p2_hit_ev)
                    p2_health <= (p2_health < DMG) ? 8'd0 : p2_health - DMG;

                if (p1_hit_ev)                 p1_stun_cnt <= STUN_INI;
                else if (p1_stun_cnt != 6'd0)  p1_stun_cnt <= p1_stun_cnt - 6'd1;
                if (p2_hit_ev)                 p2_stun_cnt <= STUN_INI;
                else if (p2_stun_cnt != 6'd0)  p2_stun_cnt <= p2_stun_cnt - 6'd1;

                // A connect latches until the attacker leaves its active frames.
                if (p1_state != ST_ACTIVE) p1_conn <= 1'b0;
                else if (p1_cand)          p1_conn <= 1'b1;
                if (p2_state != ST_ACTIVE) p2_conn <= 1'b0;
                else if (p2_cand)          p2_conn <= 1'b1;

                if (in_fight && (state_d == OVER))
                    winner <= {p1_health == 8'd0, p2_health == 8'd0};
            end
        end
    end

    assign p1_stun = (p1_stun_cnt != 6'd0);
    assign p2_stun = (p2_stun_cnt != 6'd0);

endmodule

// File: tb/tb_hit_resolver.sv
// Directed bench for hit_resolver: hit, range edges, block, stun immunity,
// trade KO with round restart, and asynchronous reset during stun.
module tb_hit_resolver;

    logic       clk;
    logic       reset;
    logic       new_round;
    logic [9:0] p1_x, p2_x;
    logic [2:0] p1_state, p2_state;
    logic       p1_hit, p2_hit, p1_blocked, p2_blocked;
    logic [7:0] p1_health, p2_health;
    logic       p1_stun, p2_stun, round_over;
    logic [1:0] winner;

    int total = 0;
    int bad   = 0;

    hit_resolver dut (
        .clk        (clk),
        .reset      (reset),
        .new_round  (new_round),
        .p1_x       (p1_x),
        .p1_state   (p1_state),
        .p2_x       (p2_x),
        .p2_state   (p2_state),
        .p1_hit     (p1_hit),
        .p2_hit     (p2_hit),
        .p1_blocked (p1_blocked),
        .p2_blocked (p2_blocked),
        .p1_health  (p1_health),
        .p2_health  (p2_health),
        .p1_stun    (p1_stun),
        .p2_stun    (p2_stun),
        .round_over (round_over),
        .winner     (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One active frame from the selected players, then idle long enough for any stun to expire.
    task automatic strike(input logic a1, input logic a2);
        p1_state = a1 ? 3'd5 : 3'd0;
        p2_state = a2 ? 3'd5 : 3'd0;
        tick();
        p1_state = 3'd0;
        p2_state = 3'd0;
        repeat (13) tick();
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        new_round = 1'b0;
        p1_x      = 10'd100;
        p2_x      = 10'd180;
        p1_state  = 3'd0;
        p2_state  = 3'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_p1_health", p1_health, 100);
        check("rst_p2_health", p2_health, 100);
        check("rst_stun", {p1_stun, p2_stun}, 0);
        check("rst_pulses", {p1_hit, p2_hit, p1_blocked, p2_blocked}, 0);
        check("rst_round_over", round_over, 0);
        check("rst_winner", winner, 0);

        // Clean hit, held active for two frames
        p1_state = 3'd5;
        tick();
        check("hit_p2_hit", p2_hit, 1);
        check("hit_p1_hit", p1_hit, 0);
        check("hit_p2_health", p2_health, 90);
        check("hit_p2_stun", p2_stun, 1);
        tick();
        check("hit_second_frame", p2_hit, 0);
        check("hit_health_once", p2_health, 90);
        p1_state = 3'd0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (p2_stun) n++;
        end
        check("stun_remaining_frames", n, 10);
        tick();
        check("stun_expired", p2_stun, 0);

        // Range edges
        p2_x = 10'd195;
        p1_state = 3'd5;
        tick();
        check("edge195_hit", p2_hit, 1);
        check("edge195_health", p2_health, 80);
        p1_state = 3'd0;
        repeat (13) tick();
        p2_x = 10'd196;
        p1_state = 3'd5;
        tick();
        check("edge196_nohit", p2_hit, 0);
        check("edge196_health", p2_health, 80);
        p2_x = 10'd100;
        tick();
        check("edge100_nohit", p2_hit, 0);
        check("edge100_health", p2_health, 80);
        p1_state = 3'd0;
        p2_x = 10'd180;
        tick();

        // Block
        p2_state = 3'd2;
        p1_state = 3'd5;
        tick();
        check("blk_pulse", p2_blocked, 1);
        check("blk_nohit", p2_hit, 0);
        check("blk_health", p2_health, 80);
        check("blk_stun", p2_stun, 0);
        tick();
        check("blk_once", p2_blocked, 0);
        p1_state = 3'd0;
        p2_state = 3'd0;
        tick();

        // Stun invulnerability
        p1_state = 3'd5;
        tick();
        check("inv_first_hit", p2_hit, 1);
        check("inv_first_health", p2_health, 70);
        p1_state = 3'd0;
        repeat (4) tick();
        check("inv_still_stunned", p2_stun, 1);
        p1_state = 3'd5;
        tick();
        check("inv_no_pulse", p2_hit, 0);
        check("inv_health_kept", p2_health, 70);
        p1_state = 3'd0;
        repeat (12) tick();
        check("inv_stun_over", p2_stun, 0);
        p1_state = 3'd5;
        tick();
        check("inv_third_hit", p2_hit, 1);
        check("inv_third_health", p2_health, 60);
        p1_state = 3'd0;
        repeat (13) tick();

        // P2 hits P1 four times, then five trades bring both to 10
        p1_state = 3'd0;
        p2_state = 3'd5;
        tick();
        check("p2atk_p1_hit", p1_hit, 1);
        check("p2atk_p1_stun", p1_stun, 1);
        check("p2atk_p2_hit", p2_hit, 0);
        p2_state = 3'd0;
        repeat (13) tick();
        repeat (3) strike(1'b0, 1'b1);
        check("p2atk_p1_health", p1_health, 60);
        p2_x = 10'd150;
        repeat (5) strike(1'b1, 1'b1);
        check("pre_ko_p1_health", p1_health, 10);
        check("pre_ko_p2_health", p2_health, 10);

        // Trade to KO
        p1_state = 3'd5;
        p2_state = 3'd5;
        tick();
        check("ko_pulses", {p1_hit, p2_hit}, 2'b11);
        check("ko_healths", {p1_health, p2_health}, 16'h0000);
        check("ko_not_over_yet", round_over, 0);
        tick();
        check("ko_round_over", round_over, 1);
        check("ko_winner_draw", winner, 3);
        check("ko_no_pulses", {p1_hit, p2_hit}, 0);
        p1_state = 3'd0;
        p2_state = 3'd0;
        repeat (14) tick();
        check("over_stun_drained", {p1_stun, p2_stun}, 0);
        p1_state = 3'd5;
        p2_state = 3'd5;
        tick();
        check("over_no_pulses", {p1_hit, p2_hit, p1_blocked, p2_blocked}, 0);
        check("over_health_frozen", {p1_health, p2_health}, 16'h0000);
        check("over_winner_frozen", winner, 3);
        p1_state = 3'd0;
        p2_state = 3'd0;
        new_round = 1'b1;
        tick();
        new_round = 1'b0;
        check("restart_health", {p1_health, p2_health}, 16'h6464);
        check("restart_winner", winner, 0);
        check("restart_round_over", round_over, 0);

        // new_round ignored during FIGHT
        p2_x = 10'd180;
        p1_state = 3'd5;
        tick();
        p1_state = 3'd0;
        new_round = 1'b1;
        tick();
        new_round = 1'b0;
        check("fight_newround_ignored", p2_health, 90);
        check("fight_stun_before_rst", p2_stun, 1);

        // Asynchronous reset mid-stun, observed before the next clock edge
        reset = 1'b1;
        #2;
        check("arst_p2_health", p2_health, 100);
        check("arst_stun", {p1_stun, p2_stun}, 0);
        check("arst_winner", winner, 0);
        #1 reset = 1'b0;
        tick();
        check("arst_after_release", {p2_stun, round_over}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
